dmem_bridge: RTL and testbench

Data-side memory bridge that sits directly downstream of the MIPS core's memory stage. It takes the core's M-stage access (address, store data, write flag, size) and issues a single request/acknowledge transaction to a variable-latency data memory slave. It generates byte strobes, replicates store data across byte lanes, and aligns and sign- or zero-extends load data. It stalls the pipeline until the transaction completes and flags misaligned accesses instead of issuing them.

---
 rtl/dmem_bridge_pkg.sv | 42 ++++
 rtl/dmem_bridge_if.sv | 21 ++
 rtl/dmem_bridge_load_align.sv | 25 ++
 rtl/dmem_bridge.sv | 87 ++++++++
 tb/tb_dmem_bridge.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared encodings and helpers for the data-side memory bridge: access sizes, FSM states,
// alignment check, byte strobes and store-lane replication.
package dmem_bridge_pkg;

    localparam int NLANES = 4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Reserved size 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [NLANES-1:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_B:    return {4{wd[7:0]}};
            SZ_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/acknowledge bus between the bridge (master) and a variable-latency data memory (slave).
// Request fields are held stable from bus_req rise until the ack cycle.
interface dmem_bridge_if #(parameter int ADDR_W = 32) ();
    logic              bus_req;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_bridge_load_align.sv
// Load lane select plus sign/zero extension; purely combinational, no flow control.
module dmem_bridge_load_align
    import dmem_bridge_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{off, 3'b000} +: 8];
        half_sel = off[1] ? raw[31:16] : raw[15:0];
        case (size)
            SZ_B:    data = zext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    data = zext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage to req/ack data-memory bridge. Latency: 1 issue cycle + slave WAIT cycles, result in DONE.
// Stalls the pipeline while a transaction is outstanding; misaligned accesses trap and are never issued.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enM,
    input  logic              memwriteM,
    input  logic [1:0]        sizeM,
    input  logic              unsignedM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedataM,
    output logic [DATA_W-1:0] readdataM,
    output logic              stallM,
    output logic              adelM,
    output logic              adesM,
    dmem_bridge_if.master     bus
);

    state_t      state;
    logic        mis;
    logic        go;
    logic [1:0]  ld_off;
    logic [1:0]  ld_size;
    logic        ld_zext;
    logic [31:0] ld_data;

    assign mis    = is_misaligned(sizeM, aluoutM[1:0]);
    assign adelM  = mem_enM & ~memwriteM & mis;
    assign adesM  = mem_enM &  memwriteM & mis;
    assign go     = mem_enM & ~mis;
    assign stallM = ((state == ST_IDLE) && go) || (state == ST_WAIT);

    dmem_bridge_load_align u_load_align (
        .raw  (bus.bus_rdata),
        .off  (ld_off),
        .size (ld_size),
        .zext (ld_zext),
        .data (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wstrb <= '0;
            bus.bus_wdata <= '0;
            readdataM     <= '0;
            ld_off        <= '0;
            ld_size       <= '0;
            ld_zext       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= memwriteM;
                        bus.bus_addr  <= {aluoutM[ADDR_W-1:2], 2'b00};
                        bus.bus_wstrb <= memwriteM ? byte_strobe(sizeM, aluoutM[1:0]) : 4'b0000;
                        bus.bus_wdata <= lane_data(sizeM, writedataM);
                        ld_off        <= aluoutM[1:0];
                        ld_size       <= sizeM;
                        ld_zext       <= unsignedM;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_ack) begin
                        // Stores leave the previous load result in place.
                        if (!bus.bus_wr) readdataM <= ld_data;
                        bus.bus_req <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a small strobe-aware memory model as the slave.
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_enM;
    logic        memwriteM;
    logic [1:0]  sizeM;
    logic        unsignedM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adelM;
    logic        adesM;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [bit [31:0]];

    dmem_bridge_if #(.ADDR_W(32)) bus ();

    dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_enM    (mem_enM),
        .memwriteM  (memwriteM),
        .sizeM      (sizeM),
        .unsignedM  (unsignedM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .adelM      (adelM),
        .adesM      (adesM),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int n_wait,
                          output int stalls, output int issues, output logic stable,
                          output logic [31:0] rd, output logic [31:0] b_addr,
                          output logic [3:0] b_strb, output logic [31:0] b_wdata,
                          output logic b_wr);
        int   cyc = 0;
        int   wc = 0;
        logic done = 1'b0;
        logic prev_req = 1'b0;
        logic [31:0] tmp;
        stalls = 0; issues = 0; stable = 1'b1; rd = '0;
        b_addr = '0; b_strb = '0; b_wdata = '0; b_wr = 1'b0;
        mem_enM = 1'b1; memwriteM = wr; sizeM = sz; unsignedM = uns;
        aluoutM = a; writedataM = wd;
        while (!done && cyc < 40) begin
            @(negedge clk);
            bus.bus_ack   = 1'b0;
            bus.bus_rdata = 32'h5A5A5A5A;
            if (stallM) stalls++;
            if (bus.bus_req && !prev_req) issues++;
            prev_req = bus.bus_req;
            if (bus.bus_req) begin
                wc++;
                if (wc == 1) begin
                    b_addr = bus.bus_addr; b_strb = bus.bus_wstrb;
                    b_wdata = bus.bus_wdata; b_wr = bus.bus_wr;
                end else if (bus.bus_addr !== b_addr || bus.bus_wstrb !== b_strb ||
                             bus.bus_wdata !== b_wdata || bus.bus_wr !== b_wr) begin
                    stable = 1'b0;
                end
                if (wc == n_wait) begin
                    bus.bus_ack = 1'b1;
                    if (bus.bus_wr) begin
                        tmp = mem_rd(bus.bus_addr);
                        for (int i = 0; i < 4; i++)
                            if (bus.bus_wstrb[i]) tmp[8*i +: 8] = bus.bus_wdata[8*i +: 8];
                        mem[bus.bus_addr] = tmp;
                    end else begin
                        bus.bus_rdata = mem_rd(bus.bus_addr);
                    end
                end
            end else if (!stallM) begin
                done = 1'b1;
                rd = readdataM;
            end
            cyc++;
        end
        if (!done) chk("access_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        mem_enM = 1'b0;
    endtask

    task automatic misalign(input string tag, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a);
        logic req_seen = 1'b0;
        mem_enM = 1'b1; memwriteM = wr; sizeM = sz; unsignedM = 1'b0;
        aluoutM = a; writedataM = 32'h11223344;
        @(negedge clk);
        chk({tag, "_adel"},  {31'b0, adelM},  {31'b0, ~wr});
        chk({tag, "_ades"},  {31'b0, adesM},  {31'b0, wr});
        chk({tag, "_stall"}, {31'b0, stallM}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            req_seen |= bus.bus_req | stallM;
        end
        chk({tag, "_noreq"}, {31'b0, req_seen}, 32'd0);
        @(posedge clk);
        #1;
        mem_enM = 1'b0;
    endtask

    int          stalls, issues;
    logic        stable, b_wr, req_seen;
    logic [31:0] rd, b_addr, b_wdata;
    logic [3:0]  b_strb;

    initial begin
        rst = 1'b1; mem_enM = 1'b0; memwriteM = 1'b0; sizeM = SZ_W; unsignedM = 1'b0;
        aluoutM = '0; writedataM = '0; bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h000] = 32'h12348056;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_req",   {31'b0, bus.bus_req}, 32'd0);
        chk("rst_wr",    {31'b0, bus.bus_wr},  32'd0);
        chk("rst_addr",  bus.bus_addr,         32'd0);
        chk("rst_wstrb", {28'b0, bus.bus_wstrb}, 32'd0);
        chk("rst_wdata", bus.bus_wdata,        32'd0);
        chk("rst_rdata", readdataM,            32'd0);
        chk("rst_stall", {31'b0, stallM},      32'd0);

        // Reset arriving while a load is waiting on the slave.
        @(posedge clk); #1;
        mem_enM = 1'b1; memwriteM = 1'b0; sizeM = SZ_W; aluoutM = 32'h100;
        @(negedge clk);
        chk("rstw_stall_idle", {31'b0, stallM}, 32'd1);
        @(posedge clk); #1;
        chk("rstw_req_wait", {31'b0, bus.bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_req_drop", {31'b0, bus.bus_req}, 32'd0);
        mem_enM = 1'b0;
        @(negedge clk);
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEADBEEF;
        @(posedge clk); #1 rst = 1'b0;
        req_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            req_seen |= bus.bus_req | stallM;
        end
        chk("rstw_stray_ack", {31'b0, req_seen}, 32'd0);
        chk("rstw_rdata",     readdataM,         32'd0);
        bus.bus_ack = 1'b0;
        @(posedge clk); #1;

        access(1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 3, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("lw_addr",   b_addr,          32'h100);
        chk("lw_wstrb",  {28'b0, b_strb}, 32'h0);
        chk("lw_wr",     {31'b0, b_wr},   32'd0);
        chk("lw_stall",  stalls,          32'd4);
        chk("lw_stable", {31'b0, stable}, 32'd1);
        chk("lw_data",   rd,              32'hDEADBEEF);

        access(1'b1, SZ_B, 1'b0, 32'h203, 32'h000000A5, 1, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("sb_addr",  b_addr,          32'h200);
        chk("sb_wstrb", {28'b0, b_strb}, 32'h8);
        chk("sb_wdata", b_wdata,         32'hA5A5A5A5);
        chk("sb_wr",    {31'b0, b_wr},   32'd1);
        chk("sb_stall", stalls,          32'd2);
        chk("sb_mem",   mem_rd(32'h200), 32'hA5000000);

        access(1'b0, SZ_B, 1'b0, 32'h001, 32'h0, 2, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("lb_addr",  b_addr, 32'h0);
        chk("lb_stall", stalls, 32'd3);
        chk("lb_data",  rd,     32'hFFFFFF80);

        access(1'b0, SZ_H, 1'b1, 32'h002, 32'h0, 1, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("lhu_data", rd, 32'h00001234);

        access(1'b0, SZ_H, 1'b0, 32'h000, 32'h0, 1, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("lh_data", rd, 32'hFFFF8056);

        access(1'b1, SZ_H, 1'b0, 32'h302, 32'h0000BEEF, 1, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("sh_wstrb", {28'b0, b_strb}, 32'hC);
        chk("sh_wdata", b_wdata,         32'hBEEFBEEF);

        misalign("lw_mis", 1'b0, SZ_W, 32'h102);
        misalign("sh_mis", 1'b1, SZ_H, 32'h003);
        chk("rd_hold", readdataM, 32'hFFFF8056);

        access(1'b1, SZ_W, 1'b0, 32'h010, 32'hCAFEF00D, 1, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("sw_issues", issues,          32'd1);
        chk("sw_wstrb",  {28'b0, b_strb}, 32'hF);
        chk("sw_stall",  stalls,          32'd2);
        access(1'b0, SZ_W, 1'b0, 32'h010, 32'h0, 1, stalls, issues, stable, rd, b_addr, b_strb, b_wdata, b_wr);
        chk("lw2_issues", issues, 32'd1);
        chk("lw2_wr",     {31'b0, b_wr}, 32'd0);
        chk("lw2_data",   rd,     32'hCAFEF00D);
        req_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            req_seen |= bus.bus_req;
        end
        chk("no_reissue", {31'b0, req_seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
